// File: rtl/block_mean_pkg.sv
// ============================================================================
//  Module      : block_mean_pkg
//  Description : Shared constants and helpers for the backlight block-mean
//                calculator (default geometry, derived widths, clog2).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package block_mean_pkg;

    // Ceiling log2, never less than 1 so it can size a port
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return (r < 1) ? 1 : r;
    endfunction

    localparam int H_ACTIVE_DEF   = 1024;
    localparam int V_ACTIVE_DEF   = 768;
    localparam int BLK_W_LOG2_DEF = 6;
    localparam int BLK_H_LOG2_DEF = 6;

    localparam int BLK_COLS = H_ACTIVE_DEF >> BLK_W_LOG2_DEF;
    localparam int BLK_ROWS = V_ACTIVE_DEF >> BLK_H_LOG2_DEF;
    localparam int ACC_W    = 8 + BLK_W_LOG2_DEF + BLK_H_LOG2_DEF;
    localparam int BX_W     = clog2(BLK_COLS);
    localparam int BY_W     = clog2(BLK_ROWS);

endpackage

`default_nettype wire

// File: rtl/block_mean_round.sv
// ============================================================================
//  Module      : block_mean_round
//  Description : Converts a block sum into an 8-bit mean: shift, optional
//                round-half-up, saturate to 255. Purely combinational.
//                Build macro BLOCK_MEAN_ROUND_EN enables rounding; otherwise
//                the mean is a truncating shift.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module block_mean_round #(
    parameter int ACC_W = 20,
    parameter int SHIFT = 12
) (
    input  logic [ACC_W-1:0] total,
    output logic [7:0]       mean
);

    logic [ACC_W:0] biased;
    logic [ACC_W:0] shifted;

`ifdef BLOCK_MEAN_ROUND_EN
    localparam logic [ACC_W:0] HALF = (ACC_W+1)'(1) << (SHIFT - 1);
    // Add half an LSB of the result before shifting (round half up)
    assign biased = {1'b0, total} + HALF;
`else
    // Plain truncation
    assign biased = {1'b0, total};
`endif

    assign shifted = biased >> SHIFT;

    // Clamp so a rounded 255.5 cannot wrap to 0
    assign mean = (shifted > (ACC_W+1)'(255)) ? 8'hFF : shifted[7:0];

endmodule

`default_nettype wire

// File: rtl/block_mean_calc.sv
// ============================================================================
//  Module      : block_mean_calc
//  Description : Mean luma per BLK_W x BLK_H backlight block from the active
//                video stream. Stage 1 sums line segments, stage 2 folds them
//                into per-column accumulators and emits the mean on the last
//                line of each block row. Optional build macro:
//                BLOCK_MEAN_ROUND_EN (round-to-nearest mean).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module block_mean_calc
    import block_mean_pkg::*;
#(
    parameter  int H_ACTIVE   = H_ACTIVE_DEF,
    parameter  int V_ACTIVE   = V_ACTIVE_DEF,
    parameter  int BLK_W_LOG2 = BLK_W_LOG2_DEF,
    parameter  int BLK_H_LOG2 = BLK_H_LOG2_DEF,
    localparam int N_COLS     = H_ACTIVE >> BLK_W_LOG2,
    localparam int N_ROWS     = V_ACTIVE >> BLK_H_LOG2,
    localparam int XB_W       = clog2(N_COLS),
    localparam int YB_W       = clog2(N_ROWS)
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            vsync_i,
    input  logic            de_i,
    input  logic [7:0]      luma_i,
    output logic [7:0]      block_mean_o,
    output logic            data_valid_o,
    output logic [XB_W-1:0] block_x_o,
    output logic [YB_W-1:0] block_y_o,
    output logic            frame_done_o
);

    localparam int SHIFT = BLK_W_LOG2 + BLK_H_LOG2;
    localparam int SUM_W = 8 + SHIFT;
    localparam int SEG_W = 8 + BLK_W_LOG2;
    localparam int XW    = clog2(H_ACTIVE + 1);
    localparam int YW    = clog2(V_ACTIVE + 1);
    localparam logic [XW-1:0] X_MAX = XW'(H_ACTIVE);
    localparam logic [YW-1:0] Y_MAX = YW'(V_ACTIVE);

    logic              vsync_d, de_d, active;
    logic [XW-1:0]     x;
    logic [YW-1:0]     y;
    logic [SEG_W-1:0]  seg_sum, seg_fin, seg_base, seg_next;
    logic              seg_vld, seg_last;
    logic [XB_W-1:0]   seg_bx;
    logic [YB_W-1:0]   seg_by;
    logic [SUM_W-1:0]  col_acc [N_COLS];
    logic [SUM_W-1:0]  total;
    logic [7:0]        mean;
    logic              vs_rise, de_rise, de_fall, accept, seg_end;

    assign vs_rise  = vsync_i & ~vsync_d;
    assign de_rise  = de_i & ~de_d;
    assign de_fall  = ~de_i & de_d;
    assign accept   = active & de_i & (x < X_MAX) & (y < Y_MAX);
    assign seg_end  = &x[BLK_W_LOG2-1:0];
    // A new line always starts a fresh segment, dropping any short-line tail
    assign seg_base = de_rise ? '0 : seg_sum;
    assign seg_next = seg_base + SEG_W'(luma_i);
    assign total    = col_acc[seg_bx] + SUM_W'(seg_fin);

    block_mean_round #(
        .ACC_W (SUM_W),
        .SHIFT (SHIFT)
    ) u_round (
        .total (total),
        .mean  (mean)
    );

    // Edge detectors and frame-active flag (input ignored until first vsync)
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vsync_d <= 1'b0;
            de_d    <= 1'b0;
            active  <= 1'b0;
        end else begin
            vsync_d <= vsync_i;
            de_d    <= de_i;
            if (vs_rise) begin
                active <= 1'b1;
            end
        end
    end

    // Pixel/line position counters, saturating just past the active area
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            x <= '0;
            y <= '0;
        end else if (vs_rise) begin
            x <= '0;
            y <= '0;
        end else if (de_fall) begin
            x <= '0;
            if (y < Y_MAX) begin
                y <= y + 1'b1;
            end
        end else if (de_i && (x < X_MAX)) begin
            x <= x + 1'b1;
        end
    end

    // Stage 1: line-segment sum, registered with its block coordinates
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            seg_sum  <= '0;
            seg_fin  <= '0;
            seg_vld  <= 1'b0;
            seg_bx   <= '0;
            seg_by   <= '0;
            seg_last <= 1'b0;
        end else begin
            seg_vld <= 1'b0;
            if (vs_rise) begin
                seg_sum <= '0;
            end else if (accept) begin
                if (seg_end) begin
                    seg_sum  <= '0;
                    seg_vld  <= 1'b1;
                    seg_fin  <= seg_next;
                    seg_bx   <= x[BLK_W_LOG2 +: XB_W];
                    seg_by   <= y[BLK_H_LOG2 +: YB_W];
                    seg_last <= &y[BLK_H_LOG2-1:0];
                end else begin
                    seg_sum <= seg_next;
                end
            end
        end
    end

    // Stage 2: column accumulation and mean output on a block's last line
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < N_COLS; i++) begin
                col_acc[i] <= '0;
            end
            block_mean_o <= '0;
            data_valid_o <= 1'b0;
            block_x_o    <= '0;
            block_y_o    <= '0;
            frame_done_o <= 1'b0;
        end else begin
            data_valid_o <= 1'b0;
            frame_done_o <= 1'b0;
            if (vs_rise) begin
                for (int i = 0; i < N_COLS; i++) begin
                    col_acc[i] <= '0;
                end
            end else if (seg_vld) begin
                if (seg_last) begin
                    block_mean_o    <= mean;
                    data_valid_o    <= 1'b1;
                    block_x_o       <= seg_bx;
                    block_y_o       <= seg_by;
                    frame_done_o    <= (seg_bx == XB_W'(N_COLS - 1)) &&
                                       (seg_by == YB_W'(N_ROWS - 1));
                    col_acc[seg_bx] <= '0;
                end else begin
                    col_acc[seg_bx] <= total;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_block_mean_calc.sv
// ============================================================================
//  Module      : tb_block_mean_calc
//  Description : Directed self-checking bench for block_mean_calc, using a
//                scaled geometry (64x48 frame, 8x8 blocks -> 8x6 blocks).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_block_mean_calc;

    localparam int H    = 64;
    localparam int V    = 48;
    localparam int COLS = 8;
    localparam int ROWS = 6;
    localparam int NBLK = COLS * ROWS;
`ifdef BLOCK_MEAN_ROUND_EN
    localparam int RAMP_MEAN = 123;   // 7840/64 = 122.5 rounded
`else
    localparam int RAMP_MEAN = 122;   // 7840/64 = 122.5 truncated
`endif

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       vsync = 1'b0;
    logic       de = 1'b0;
    logic [7:0] luma = 8'd0;
    logic [7:0] mean;
    logic       dv;
    logic [2:0] bx;
    logic [2:0] by;
    logic       fd;

    always #5 clk = ~clk;

    block_mean_calc #(
        .H_ACTIVE   (H),
        .V_ACTIVE   (V),
        .BLK_W_LOG2 (3),
        .BLK_H_LOG2 (3)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .vsync_i      (vsync),
        .de_i         (de),
        .luma_i       (luma),
        .block_mean_o (mean),
        .data_valid_o (dv),
        .block_x_o    (bx),
        .block_y_o    (by),
        .frame_done_o (fd)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int pix_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: records each valid block, raster order, frame_done
    logic mon_clr = 1'b0;
    int   vcnt, order_err, fd_cnt, fd_err, mon_idx;
    int   got  [NBLK];
    int   vcyc [NBLK];

    always @(negedge clk) begin
        if (mon_clr) begin
            vcnt = 0; order_err = 0; fd_cnt = 0; fd_err = 0;
            for (int i = 0; i < NBLK; i++) begin
                got[i]  = -1;
                vcyc[i] = -1;
            end
        end else if (rstn) begin
            if (dv) begin
                mon_idx = int'(by) * COLS + int'(bx);
                if (mon_idx != vcnt) order_err++;
                if (mon_idx < NBLK) begin
                    got[mon_idx]  = int'(mean);
                    vcyc[mon_idx] = cyc;
                end
                vcnt++;
            end
            if (fd) begin
                fd_cnt++;
                if (!dv || bx != 3'd7 || by != 3'd5) fd_err++;
            end
        end
    end

    // Pixel patterns: 0 const 100, 1 ramp, 2 hot block (3,2), 3 const 200
    function automatic logic [7:0] pix(input int mode, input int x, input int y);
        case (mode)
            0:       return 8'd100;
            1:       return 8'((x % 8) * 35);
            2:       return ((x / 8 == 3) && (y / 8 == 2)) ? 8'd255 : 8'd0;
            default: return 8'd200;
        endcase
    endfunction

    task automatic clear_mon();
        @(posedge clk); mon_clr = 1'b1;
        @(posedge clk); mon_clr = 1'b0;
    endtask

    task automatic vsync_pulse();
        @(negedge clk); vsync = 1'b1;
        @(negedge clk);
        @(negedge clk); vsync = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic drive_line(input int mode, input int y, input int npix);
        for (int x = 0; x < npix; x++) begin
            @(negedge clk);
            de   = 1'b1;
            luma = pix(mode, x, y);
            if (x == 31 && y == 23) pix_cyc = cyc;
        end
        @(negedge clk); de = 1'b0; luma = 8'd0;
        repeat (7) @(negedge clk);
    endtask

    task automatic drive_lines(input int mode, input int y0, input int y1, input int npix);
        for (int y = y0; y < y1; y++) drive_line(mode, y, npix);
    endtask

    task automatic test_reset();
        int bad;
        repeat (3) @(negedge clk);
        checks++;
        if ({mean, dv, bx, by, fd} !== 16'h0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0000", {mean, dv, bx, by, fd});
        end
        @(negedge clk); rstn = 1'b1;
        clear_mon();
        drive_lines(0, 0, V, H);
        checks++;
        if (vcnt != 0) begin
            errors++;
            $display("FAIL no_vsync_discard: got %0d valids expected 0", vcnt);
        end
        bad = 0;
    endtask

    task automatic test_const(input int npix, input int nlines, input string tag);
        int bad;
        clear_mon();
        vsync_pulse();
        drive_lines(0, 0, nlines, npix);
        repeat (4) @(negedge clk);
        bad = 0;
        for (int i = 0; i < NBLK; i++) if (got[i] != 100) bad++;
        checks++;
        if (vcnt != NBLK) begin errors++; $display("FAIL %s_count: got %0d expected %0d", tag, vcnt, NBLK); end
        checks++;
        if (order_err != 0) begin errors++; $display("FAIL %s_order: got %0d errors expected 0", tag, order_err); end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL %s_means: got %0d wrong (blk0=%0d) expected 0", tag, bad, got[0]); end
        checks++;
        if (fd_cnt != 1 || fd_err != 0) begin errors++; $display("FAIL %s_frame_done: got cnt %0d err %0d expected 1/0", tag, fd_cnt, fd_err); end
        checks++;
        if (dv !== 1'b0 || mean !== 8'd100 || bx !== 3'd7 || by !== 3'd5) begin
            errors++;
            $display("FAIL %s_hold: got dv %b mean %0d x %0d y %0d expected 0/100/7/5", tag, dv, mean, bx, by);
        end
    endtask

    task automatic test_ramp();
        int bad;
        clear_mon();
        vsync_pulse();
        drive_lines(1, 0, V, H);
        repeat (4) @(negedge clk);
        bad = 0;
        for (int i = 0; i < NBLK; i++) if (got[i] != RAMP_MEAN) bad++;
        checks++;
        if (vcnt != NBLK) begin errors++; $display("FAIL ramp_count: got %0d expected %0d", vcnt, NBLK); end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL ramp_means: got %0d wrong (blk0=%0d) expected mean %0d", bad, got[0], RAMP_MEAN); end
        checks++;
        if (fd_cnt != 1 || fd_err != 0) begin errors++; $display("FAIL ramp_frame_done: got cnt %0d err %0d expected 1/0", fd_cnt, fd_err); end
    endtask

    task automatic test_hot_block();
        int bad;
        clear_mon();
        vsync_pulse();
        drive_lines(2, 0, V, H);
        repeat (4) @(negedge clk);
        bad = 0;
        for (int i = 0; i < NBLK; i++) if (i != 19 && got[i] != 0) bad++;
        checks++;
        if (got[19] != 255) begin errors++; $display("FAIL hot_mean: got %0d expected 255", got[19]); end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL hot_others: got %0d nonzero expected 0", bad); end
        checks++;
        if (vcyc[19] - pix_cyc != 2) begin errors++; $display("FAIL hot_latency: got %0d cycles expected 2", vcyc[19] - pix_cyc); end
        checks++;
        if (vcnt != NBLK || order_err != 0) begin errors++; $display("FAIL hot_count: got %0d/%0d expected %0d/0", vcnt, order_err, NBLK); end
    endtask

    task automatic test_reset_midframe();
        int bad;
        clear_mon();
        vsync_pulse();
        drive_lines(1, 0, 20, H);
        checks++;
        if (vcnt != 16) begin errors++; $display("FAIL rst_pre_count: got %0d expected 16", vcnt); end
        for (int x = 0; x < 10; x++) begin
            @(negedge clk); de = 1'b1; luma = pix(1, x, 20);
        end
        @(negedge clk); rstn = 1'b0;
        #1;
        checks++;
        if ({mean, dv, bx, by, fd} !== 16'h0) begin
            errors++;
            $display("FAIL rst_mid_outputs: got %h expected 0000", {mean, dv, bx, by, fd});
        end
        repeat (4) @(negedge clk);
        de = 1'b0; rstn = 1'b1;
        repeat (7) @(negedge clk);
        drive_lines(1, 21, V, H);
        checks++;
        if (vcnt != 16) begin errors++; $display("FAIL rst_discard: got %0d valids expected 16", vcnt); end
        clear_mon();
        vsync_pulse();
        drive_lines(1, 0, V, H);
        repeat (4) @(negedge clk);
        bad = 0;
        for (int i = 0; i < NBLK; i++) if (got[i] != RAMP_MEAN) bad++;
        checks++;
        if (vcnt != NBLK || bad != 0) begin errors++; $display("FAIL rst_next_frame: got %0d valids %0d wrong expected %0d/0", vcnt, bad, NBLK); end
        checks++;
        if (fd_cnt != 1 || fd_err != 0) begin errors++; $display("FAIL rst_next_fd: got cnt %0d err %0d expected 1/0", fd_cnt, fd_err); end
    endtask

    task automatic test_vsync_midframe();
        int bad;
        clear_mon();
        vsync_pulse();
        drive_lines(3, 0, 26, H);
        checks++;
        if (vcnt != 24 || got[0] != 200) begin errors++; $display("FAIL vs_pre: got %0d valids blk0 %0d expected 24/200", vcnt, got[0]); end
        clear_mon();
        vsync_pulse();
        checks++;
        if (vcnt != 0) begin errors++; $display("FAIL vs_abandon: got %0d valids expected 0", vcnt); end
        drive_lines(0, 0, V, H);
        repeat (4) @(negedge clk);
        bad = 0;
        for (int i = 0; i < NBLK; i++) if (got[i] != 100) bad++;
        checks++;
        if (got[24] != 100) begin errors++; $display("FAIL vs_stale_acc: got %0d expected 100", got[24]); end
        checks++;
        if (vcnt != NBLK || bad != 0 || fd_cnt != 1) begin
            errors++;
            $display("FAIL vs_new_frame: got %0d valids %0d wrong fd %0d expected %0d/0/1", vcnt, bad, fd_cnt, NBLK);
        end
    endtask

    initial begin
        clear_mon();
        test_reset();
        test_const(H, V, "const");
        test_ramp();
        test_hot_block();
        test_reset_midframe();
        test_vsync_midframe();
        test_const(H + 6, V + 2, "overlong");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
